reg_file_mp: RTL

REG_FILE_MP -- requirements
Module: reg_file_mp

---
 rtl/reg_file_pkg.sv | 14 +
 rtl/reg_clr_seq.sv | 60 ++++++
 rtl/reg_file_mp.sv | 106 ++++++++++
 3 files changed

// File: rtl/reg_file_pkg.sv
// Shared definitions for the multi-port register file: default sizes and the
// clear-sweep state encoding.
package reg_file_pkg;

  localparam int DEF_DATA_WIDTH = 64;
  localparam int DEF_ADDR_WIDTH = 4;
  localparam int DEF_NUM_RD     = 3;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } clr_state_e;

endpackage

// File: rtl/reg_clr_seq.sv
// Bulk-clear sequencer: walks a pointer over registers 1..DEPTH-1, one per
// cycle, emitting a clear strobe and the address to zero.
module reg_clr_seq
  import reg_file_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr_req_i,
  output logic                  clr_busy_o,
  output logic                  clr_en_o,
  output logic [ADDR_WIDTH-1:0] clr_addr_o
);

  localparam logic [ADDR_WIDTH-1:0] PTR_FIRST = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH-1:0] PTR_LAST  = '1;

  clr_state_e            state_q, state_d;
  logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= PTR_FIRST;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  // A new request while sweeping is ignored; the pointer rewinds on exit.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    unique case (state_q)
      IDLE: begin
        ptr_d = PTR_FIRST;
        if (clr_req_i) state_d = CLEAR;
      end
      CLEAR: begin
        if (ptr_q == PTR_LAST) begin
          state_d = IDLE;
          ptr_d   = PTR_FIRST;
        end else begin
          ptr_d = ptr_q + PTR_FIRST;
        end
      end
      default: begin
        state_d = IDLE;
        ptr_d   = PTR_FIRST;
      end
    endcase
  end

  assign clr_busy_o = (state_q == CLEAR);
  assign clr_en_o   = (state_q == CLEAR);
  assign clr_addr_o = ptr_q;

endmodule

// File: rtl/reg_file_mp.sv
// Two-write, NUM_RD-read register file with r0 hard-wired to zero, write
// forwarding and a bulk clear sweep. Optional pending-bit scoreboard is built
// only when REG_FILE_SCOREBOARD_EN is defined.
module reg_file_mp
  import reg_file_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int NUM_RD     = DEF_NUM_RD
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         we0,
  input  logic [ADDR_WIDTH-1:0]        waddr0,
  input  logic [DATA_WIDTH-1:0]        wdata0,
  input  logic                         we1,
  input  logic [ADDR_WIDTH-1:0]        waddr1,
  input  logic [DATA_WIDTH-1:0]        wdata1,
  input  logic [NUM_RD*ADDR_WIDTH-1:0] raddr,
  output logic [NUM_RD*DATA_WIDTH-1:0] rdata,
  output logic                         wr_ready,
  input  logic                         clr_req,
  output logic                         clr_busy,
  input  logic                         alloc_en,
  input  logic [ADDR_WIDTH-1:0]        alloc_addr,
  output logic [NUM_RD-1:0]            rd_pend
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic                  clrEn;
  logic [ADDR_WIDTH-1:0] clrAddr;
  logic                  wrAcc0, wrAcc1;

  reg_clr_seq #(.ADDR_WIDTH(ADDR_WIDTH)) u_clr_seq (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr_req_i (clr_req),
    .clr_busy_o(clr_busy),
    .clr_en_o  (clrEn),
    .clr_addr_o(clrAddr)
  );

  assign wr_ready = !clr_busy;
  assign wrAcc0   = we0 && wr_ready && (waddr0 != '0);
  assign wrAcc1   = we1 && wr_ready && (waddr1 != '0);

  // Port 1 is applied last so it wins a same-address collision.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (clrEn) begin
      mem_q[clrAddr] <= '0;
    end else begin
      if (wrAcc0) mem_q[waddr0] <= wdata0;
      if (wrAcc1) mem_q[waddr1] <= wdata1;
    end
  end

`ifdef REG_FILE_SCOREBOARD_EN
  logic [DEPTH-1:0] pend_q;
  logic             allocAcc;

  assign allocAcc = alloc_en && wr_ready && (alloc_addr != '0);

  // Alloc is applied after the write clears so a same-cycle alloc keeps the bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q <= '0;
    end else if (clrEn) begin
      pend_q[clrAddr] <= 1'b0;
    end else begin
      if (wrAcc0)   pend_q[waddr0]     <= 1'b0;
      if (wrAcc1)   pend_q[waddr1]     <= 1'b0;
      if (allocAcc) pend_q[alloc_addr] <= 1'b1;
    end
  end
`else
  logic unusedAlloc;
  assign unusedAlloc = ^{alloc_en, alloc_addr};
`endif

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_WIDTH-1:0] rdAddr;
    logic [DATA_WIDTH-1:0] rdVal;

    assign rdAddr = raddr[k*ADDR_WIDTH +: ADDR_WIDTH];

    always_comb begin
      rdVal = mem_q[rdAddr];
      if (rdAddr == '0)                         rdVal = '0;
      else if (wrAcc1 && (waddr1 == rdAddr))    rdVal = wdata1;
      else if (wrAcc0 && (waddr0 == rdAddr))    rdVal = wdata0;
    end

    assign rdata[k*DATA_WIDTH +: DATA_WIDTH] = rdVal;

`ifdef REG_FILE_SCOREBOARD_EN
    assign rd_pend[k] = (rdAddr != '0) && pend_q[rdAddr];
`else
    assign rd_pend[k] = 1'b0;
`endif
  end

endmodule
